// File: rtl/ptw_walk_arbiter.sv
// Arbitrates ITLB/DTLB miss walks onto the single page-table walker and steers responses back.
// Optional macro PTW_ARB_HYP_EN adds H-extension two-stage walk qualifiers (v, hlvx).
module ptw_walk_arbiter #(
    parameter int unsigned VLEN         = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            itlb_req_i,
    input  logic [VLEN-1:0] itlb_vaddr_i,
    output logic            itlb_gnt_o,
    input  logic            dtlb_req_i,
    input  logic [VLEN-1:0] dtlb_vaddr_i,
    input  logic            dtlb_is_store_i,
    output logic            dtlb_gnt_o,
`ifdef PTW_ARB_HYP_EN
    input  logic            itlb_v_i,
    input  logic            dtlb_v_i,
    input  logic            dtlb_hlvx_i,
    output logic            ptw_v_o,
    output logic            ptw_hlvx_o,
`endif
    output logic            ptw_req_o,
    output logic [VLEN-1:0] ptw_vaddr_o,
    output logic            ptw_is_store_o,
    output logic            ptw_is_instr_o,
    input  logic            ptw_ready_i,
    input  logic            ptw_rsp_valid_i,
    input  logic            ptw_rsp_err_i,
    output logic            itlb_rsp_valid_o,
    output logic            dtlb_rsp_valid_o,
    output logic            rsp_err_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e            state_q;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [VLEN-1:0]   vaddr_q;
    logic              is_store_q;
    logic              is_instr_q;
    logic              itlb_rsp_q;
    logic              dtlb_rsp_q;
    logic              rsp_err_q;
    logic              arb_en;
    logic              itlb_win;
`ifdef PTW_ARB_HYP_EN
    logic              v_q;
    logic              hlvx_q;
`endif

    // DTLB is favoured; a waiting ITLB wins once it has lost STARVE_LIMIT times in a row.
    always_comb begin
        arb_en       = (state_q == S_IDLE) && !flush_i && (itlb_req_i || dtlb_req_i);
        itlb_win     = itlb_req_i && (!dtlb_req_i || (starve_cnt_q == LIMIT));
        itlb_gnt_o   = arb_en && itlb_win;
        dtlb_gnt_o   = arb_en && !itlb_win;
        starve_cnt_d = starve_cnt_q;
        if (arb_en) begin
            if (itlb_win || !itlb_req_i) begin
                starve_cnt_d = 4'd0;
            end else if (starve_cnt_q != LIMIT) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            starve_cnt_q <= 4'd0;
            vaddr_q      <= '0;
            is_store_q   <= 1'b0;
            is_instr_q   <= 1'b0;
            itlb_rsp_q   <= 1'b0;
            dtlb_rsp_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
`ifdef PTW_ARB_HYP_EN
            v_q          <= 1'b0;
            hlvx_q       <= 1'b0;
`endif
        end else begin
            starve_cnt_q <= starve_cnt_d;
            itlb_rsp_q   <= 1'b0;
            dtlb_rsp_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (arb_en) begin
                        vaddr_q    <= itlb_win ? itlb_vaddr_i : dtlb_vaddr_i;
                        is_store_q <= !itlb_win && dtlb_is_store_i;
                        is_instr_q <= itlb_win;
`ifdef PTW_ARB_HYP_EN
                        v_q        <= itlb_win ? itlb_v_i : dtlb_v_i;
                        hlvx_q     <= !itlb_win && dtlb_hlvx_i;
`endif
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // An accepted walk must still be drained even if flushed in the same cycle.
                    if (ptw_ready_i) begin
                        state_q <= flush_i ? S_DRAIN : S_WAIT;
                    end else if (flush_i) begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (ptw_rsp_valid_i) begin
                        state_q <= S_IDLE;
                        if (!flush_i) begin
                            itlb_rsp_q <= is_instr_q;
                            dtlb_rsp_q <= !is_instr_q;
                            rsp_err_q  <= ptw_rsp_err_i;
                        end
                    end else if (flush_i) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (ptw_rsp_valid_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ptw_req_o        = (state_q == S_ISSUE);
    assign ptw_vaddr_o      = vaddr_q;
    assign ptw_is_store_o   = is_store_q;
    assign ptw_is_instr_o   = is_instr_q;
    assign itlb_rsp_valid_o = itlb_rsp_q;
    assign dtlb_rsp_valid_o = dtlb_rsp_q;
    assign rsp_err_o        = rsp_err_q;
    assign busy_o           = (state_q != S_IDLE);
`ifdef PTW_ARB_HYP_EN
    assign ptw_v_o          = v_q;
    assign ptw_hlvx_o       = hlvx_q;
`endif

endmodule

// File: tb/tb_ptw_walk_arbiter.sv
// Transaction-level bench for ptw_walk_arbiter: each walk is scripted, expectations come from
// the arbitration/flush rules applied to a per-walk model with a starvation counter.
module tb_ptw_walk_arbiter;
    localparam int LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        itlb_req_i = 1'b0;
    logic [63:0] itlb_vaddr_i = '0;
    logic        itlb_gnt_o;
    logic        dtlb_req_i = 1'b0;
    logic [63:0] dtlb_vaddr_i = '0;
    logic        dtlb_is_store_i = 1'b0;
    logic        dtlb_gnt_o;
    logic        ptw_req_o;
    logic [63:0] ptw_vaddr_o;
    logic        ptw_is_store_o;
    logic        ptw_is_instr_o;
    logic        ptw_ready_i = 1'b0;
    logic        ptw_rsp_valid_i = 1'b0;
    logic        ptw_rsp_err_i = 1'b0;
    logic        itlb_rsp_valid_o;
    logic        dtlb_rsp_valid_o;
    logic        rsp_err_o;
    logic        busy_o;
`ifdef PTW_ARB_HYP_EN
    logic        itlb_v_i = 1'b0;
    logic        dtlb_v_i = 1'b0;
    logic        dtlb_hlvx_i = 1'b0;
    logic        ptw_v_o;
    logic        ptw_hlvx_o;
`endif

    ptw_walk_arbiter #(.VLEN(64), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .itlb_req_i      (itlb_req_i),
        .itlb_vaddr_i    (itlb_vaddr_i),
        .itlb_gnt_o      (itlb_gnt_o),
        .dtlb_req_i      (dtlb_req_i),
        .dtlb_vaddr_i    (dtlb_vaddr_i),
        .dtlb_is_store_i (dtlb_is_store_i),
        .dtlb_gnt_o      (dtlb_gnt_o),
`ifdef PTW_ARB_HYP_EN
        .itlb_v_i        (itlb_v_i),
        .dtlb_v_i        (dtlb_v_i),
        .dtlb_hlvx_i     (dtlb_hlvx_i),
        .ptw_v_o         (ptw_v_o),
        .ptw_hlvx_o      (ptw_hlvx_o),
`endif
        .ptw_req_o       (ptw_req_o),
        .ptw_vaddr_o     (ptw_vaddr_o),
        .ptw_is_store_o  (ptw_is_store_o),
        .ptw_is_instr_o  (ptw_is_instr_o),
        .ptw_ready_i     (ptw_ready_i),
        .ptw_rsp_valid_i (ptw_rsp_valid_i),
        .ptw_rsp_err_i   (ptw_rsp_err_i),
        .itlb_rsp_valid_o(itlb_rsp_valid_o),
        .dtlb_rsp_valid_o(dtlb_rsp_valid_o),
        .rsp_err_o       (rsp_err_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    int starve_m = 0;
    bit exp_pend = 0;
    bit exp_own_i = 0;
    bit exp_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_rsp();
        check_val("itlb_rsp", 64'(itlb_rsp_valid_o), 64'(exp_pend && exp_own_i));
        check_val("dtlb_rsp", 64'(dtlb_rsp_valid_o), 64'(exp_pend && !exp_own_i));
        if (exp_pend) check_val("rsp_err", 64'(rsp_err_o), 64'(exp_err));
        exp_pend = 0;
    endtask

    task automatic chk_zero(input string tag);
        check_val(tag, 64'({itlb_gnt_o, dtlb_gnt_o, ptw_req_o, ptw_is_store_o, ptw_is_instr_o,
                            itlb_rsp_valid_o, dtlb_rsp_valid_o, rsp_err_o, busy_o}), 64'd0);
        check_val({tag, "_vaddr"}, ptw_vaddr_o, 64'd0);
    endtask

    // modes: 0 normal, 1 flush in ISSUE, 2 flush+ready, 3 flush in WAIT, 4 flush+rsp, 5 reset in WAIT
    task automatic do_walk(input bit ireq, input bit dreq, input logic [63:0] iva,
                           input logic [63:0] dva, input bit dst, input int rdy_dly,
                           input int wait_dly, input int fl_c, input bit err, input int mode,
                           input bit pre_flush, output bit won_i);
        bit wi;
        logic [63:0] eva;
        bit est;
        itlb_vaddr_i = iva;
        dtlb_vaddr_i = dva;
        dtlb_is_store_i = dst;
        if (pre_flush) begin
            itlb_req_i = ireq;
            dtlb_req_i = dreq;
            flush_i = 1'b1;
            @(negedge clk_i);
            chk_rsp();
            check_val("flush_idle_gnt", 64'({itlb_gnt_o, dtlb_gnt_o}), 64'd0);
            tick();
            flush_i = 1'b0;
        end
        itlb_req_i = ireq;
        dtlb_req_i = dreq;
        wi = ireq && (!dreq || starve_m == LIMIT);
        if (wi || !ireq) starve_m = 0;
        else if (starve_m < LIMIT) starve_m++;
        eva = wi ? iva : dva;
        est = wi ? 1'b0 : dst;
        @(negedge clk_i);
        chk_rsp();
        check_val("busy_idle", 64'(busy_o), 64'd0);
        check_val("gnt", 64'({itlb_gnt_o, dtlb_gnt_o}), 64'({wi, !wi}));
        won_i = itlb_gnt_o;
        tick();
        if (wi) itlb_req_i = 1'b0;
        else dtlb_req_i = 1'b0;
        for (int c = 0; c <= rdy_dly; c++) begin
            ptw_ready_i = (c == rdy_dly) && (mode != 1);
            flush_i = (c == rdy_dly) && (mode == 1 || mode == 2);
            @(negedge clk_i);
            check_val("issue_req", 64'({ptw_req_o, busy_o, itlb_gnt_o, dtlb_gnt_o}), 64'b1100);
            check_val("issue_vaddr", ptw_vaddr_o, eva);
            check_val("issue_attr", 64'({ptw_is_store_o, ptw_is_instr_o}), 64'({est, wi}));
            tick();
        end
        ptw_ready_i = 1'b0;
        flush_i = 1'b0;
        if (mode == 1) begin
            itlb_req_i = 1'b0;
            dtlb_req_i = 1'b0;
            ptw_rsp_valid_i = 1'b1;
            @(negedge clk_i);
            check_val("flush_issue_drop", 64'({ptw_req_o, busy_o}), 64'd0);
            tick();
            ptw_rsp_valid_i = 1'b0;
            return;
        end
        if (mode == 5) begin
            rst_ni = 1'b0;
            itlb_req_i = 1'b0;
            dtlb_req_i = 1'b0;
            @(negedge clk_i);
            chk_zero("rst_mid_walk");
            tick();
            rst_ni = 1'b1;
            ptw_rsp_valid_i = 1'b1;
            ptw_rsp_err_i = 1'b1;
            @(negedge clk_i);
            chk_zero("rst_after_rsp");
            tick();
            ptw_rsp_valid_i = 1'b0;
            ptw_rsp_err_i = 1'b0;
            starve_m = 0;
            return;
        end
        for (int c = 0; c < wait_dly; c++) begin
            flush_i = (mode == 3 && c == fl_c) || (mode == 2 && c == 0);
            @(negedge clk_i);
            check_val("wait_busy", 64'({busy_o, ptw_req_o, itlb_gnt_o, dtlb_gnt_o}), 64'b1000);
            check_val("wait_no_rsp", 64'({itlb_rsp_valid_o, dtlb_rsp_valid_o}), 64'd0);
            tick();
            flush_i = 1'b0;
        end
        ptw_rsp_valid_i = 1'b1;
        ptw_rsp_err_i = err;
        flush_i = (mode == 4);
        @(negedge clk_i);
        check_val("rsp_cycle_busy", 64'(busy_o), 64'd1);
        tick();
        ptw_rsp_valid_i = 1'b0;
        ptw_rsp_err_i = 1'b0;
        flush_i = 1'b0;
        exp_pend = (mode == 0);
        exp_own_i = wi;
        exp_err = err;
    endtask

    initial begin
        bit wi;
        int mode;
        int wd;
        bit ir;
        bit dr;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk_zero("reset");
        tick();
        rst_ni = 1'b1;
        tick();

        do_walk(1'b0, 1'b1, 64'd0, 64'h8000_1000, 1'b1, 0, 5, 0, 1'b0, 0, 1'b0, wi);
        check_val("donly_winner", 64'(wi), 64'd0);

        for (int k = 0; k < 10; k++) begin
            do_walk(1'b1, 1'b1, 64'h1000 + 64'(k), 64'h2000 + 64'(k), k[0], 0, 1, 0, 1'b0, 0,
                    1'b0, wi);
            check_val("starve_order", 64'(wi), 64'(k % 5 == 4));
        end

        do_walk(1'b0, 1'b1, 64'd0, 64'h3000, 1'b0, 1, 2, 0, 1'b0, 1, 1'b0, wi);
        do_walk(1'b1, 1'b0, 64'h1_0000, 64'd0, 1'b1, 0, 5, 2, 1'b0, 3, 1'b0, wi);
        do_walk(1'b0, 1'b1, 64'd0, 64'h4000, 1'b1, 0, 1, 0, 1'b1, 0, 1'b0, wi);
        check_val("after_drain_dtlb", 64'(wi), 64'd0);
        do_walk(1'b1, 1'b1, 64'h5000, 64'h6000, 1'b0, 1, 3, 0, 1'b0, 2, 1'b0, wi);
        do_walk(1'b0, 1'b1, 64'd0, 64'h7000, 1'b1, 0, 2, 0, 1'b1, 4, 1'b0, wi);

        do_walk(1'b1, 1'b1, 64'h11, 64'h22, 1'b0, 0, 1, 0, 1'b0, 0, 1'b0, wi);
        do_walk(1'b1, 1'b1, 64'h11, 64'h22, 1'b0, 0, 1, 0, 1'b0, 0, 1'b0, wi);
        do_walk(1'b1, 1'b1, 64'h11, 64'h22, 1'b0, 0, 1, 0, 1'b0, 5, 1'b0, wi);
        for (int k = 0; k < 5; k++) begin
            do_walk(1'b1, 1'b1, 64'h33, 64'h44, 1'b1, 0, 1, 0, 1'b0, 0, 1'b0, wi);
            check_val("starve_after_rst", 64'(wi), 64'(k == 4));
        end

        for (int k = 0; k < 80; k++) begin
            ir = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 3) != 0);
            if (!ir && !dr) dr = 1'b1;
            mode = $urandom_range(0, 9);
            mode = (mode < 5) ? 0 : mode - 4;
            wd = $urandom_range(1, 5);
            do_walk(ir, dr, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), wd, $urandom_range(0, wd - 1), 1'($urandom_range(0, 1)),
                    mode, ($urandom_range(0, 7) == 0), wi);
        end

        @(negedge clk_i);
        chk_rsp();
        check_val("final_idle", 64'(busy_o), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
